// File: rtl/tensor_dot_seq.sv
// Sequential 4-element 2-bit dot product using two shared multipliers.
// Optional job counter enabled by defining TENSOR_DOT_JOBCNT_EN.
module tensor_dot_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_vec,
    input  logic [7:0] b_vec,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] result,
    output logic       busy,
    output logic [7:0] job_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL0 = 2'd1,
        MUL1 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [5:0] acc_q;
    logic [5:0] res_q;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       busy_q;

    logic [1:0] m0_a;
    logic [1:0] m0_b;
    logic [1:0] m1_a;
    logic [1:0] m1_b;
    logic [3:0] prod0;
    logic [3:0] prod1;
    logic [5:0] base;
    logic [5:0] sum_d;

    // MUL0 works on elements 0/1, MUL1 on elements 2/3 and accumulates.
    always_comb begin
        m0_a = a_q[1:0];
        m0_b = b_q[1:0];
        m1_a = a_q[3:2];
        m1_b = b_q[3:2];
        base = 6'd0;
        if (state_q == MUL1) begin
            m0_a = a_q[5:4];
            m0_b = b_q[5:4];
            m1_a = a_q[7:6];
            m1_b = b_q[7:6];
            base = acc_q;
        end
        prod0 = {2'b00, m0_a} * {2'b00, m0_b};
        prod1 = {2'b00, m1_a} * {2'b00, m1_b};
        sum_d = base + {2'b00, prod0} + {2'b00, prod1};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            acc_q       <= 6'd0;
            res_q       <= 6'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a_vec;
                        b_q        <= b_vec;
                        state_q    <= MUL0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                MUL0: begin
                    acc_q   <= sum_d;
                    state_q <= MUL1;
                end
                MUL1: begin
                    acc_q       <= sum_d;
                    res_q       <= sum_d;
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef TENSOR_DOT_JOBCNT_EN
    logic [7:0] jc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            jc_q <= 8'd0;
        end else if (state_q == DONE && out_ready) begin
            jc_q <= jc_q + 8'd1;
        end
    end

    assign job_count = jc_q;
`else
    assign job_count = 8'd0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = res_q;

endmodule

// File: tb/tb_tensor_dot_seq.sv
// Self-checking bench for tensor_dot_seq: vector table, corner
// sequences and randomized jobs against a behavioural dot-product model.
module tb_tensor_dot_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_vec;
    logic [7:0] b_vec;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] result;
    logic       busy;
    logic [7:0] job_count;

    int total = 0;
    int bad   = 0;
    logic [5:0] last_res;
    logic [7:0] jc_model;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         hold;
        int         exp;
    } vec_t;

    vec_t tbl[6];

    tensor_dot_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a_vec(a_vec),
        .b_vec(b_vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .busy(busy),
        .job_count(job_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int dot_ref(input logic [7:0] a,
                                   input logic [7:0] b);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++)
            s += int'(a[2*i +: 2]) * int'(b[2*i +: 2]);
        return s;
    endfunction

    function automatic int jc_exp();
`ifdef TENSOR_DOT_JOBCNT_EN
        return int'(jc_model);
`else
        return 0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_in(input bit en);
        if (en) begin
            a_vec = 8'($urandom);
            b_vec = 8'($urandom);
        end
    endtask

    // Full job from IDLE: accept, two compute cycles, DONE held, release.
    task automatic run_job(input logic [7:0] a, input logic [7:0] b,
                           input int hold, input bit scr, input int exp);
        chk("in_ready_idle", in_ready, 1);
        a_vec     = a;
        b_vec     = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        chk("busy_mul0", busy, 1);
        chk("ov_mul0", out_valid, 0);
        chk("res_hold_mul0", result, last_res);
        scramble_in(scr);
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        step();
        chk("ov_mul1", out_valid, 0);
        chk("in_ready_mul1", in_ready, 0);
        chk("res_hold_mul1", result, last_res);
        scramble_in(scr);
        step();
        chk("ov_done", out_valid, 1);
        chk("res_done", result, exp);
        chk("in_ready_done", in_ready, 0);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            scramble_in(1'b1);
            step();
            chk("ov_hold", out_valid, 1);
            chk("res_hold_done", result, exp);
            chk("in_ready_hold", in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        jc_model = jc_model + 8'd1;
        last_res = 6'(exp);
        chk("ov_ret", out_valid, 0);
        chk("busy_ret", busy, 0);
        chk("in_ready_ret", in_ready, 1);
        chk("res_ret", result, exp);
        chk("jobcnt", job_count, jc_exp());
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n    = 1'b1;
        jc_model = 8'd0;
        last_res = 6'd0;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int jc257;

        tbl[0] = '{8'hFF, 8'hFF, 0, 36};
        tbl[1] = '{8'h1B, 8'hFF, 0, 18};
        tbl[2] = '{8'h00, 8'hFF, 1, 0};
        tbl[3] = '{8'h55, 8'hAA, 5, 8};
        tbl[4] = '{8'hE4, 8'h1B, 2, 4};
        tbl[5] = '{8'hFF, 8'h01, 0, 3};

        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_vec     = 8'h00;
        b_vec     = 8'h00;
        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_jobcnt", job_count, 0);

        for (int i = 0; i < 6; i++)
            run_job(tbl[i].a, tbl[i].b, tbl[i].hold, 1'b0, tbl[i].exp);

        // Reset while in MUL1 drops the job.
        a_vec    = 8'hFF;
        b_vec    = 8'hFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("busy_mul1_pre_rst", busy, 1);
        rst_n = 1'b0;
        step();
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_result", result, 0);
        chk("mrst_jobcnt", job_count, 0);
        rst_n    = 1'b1;
        jc_model = 8'd0;
        last_res = 6'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mrst_no_ov", out_valid, 0);
        end
        run_job(8'h1B, 8'hFF, 0, 1'b1, 18);

        // Random jobs from a fresh reset; 257 completions wrap the counter.
        do_reset();
        for (int j = 0; j < 257; j++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_job(ra, rb, $urandom_range(0, 2), 1'b1, dot_ref(ra, rb));
        end
`ifdef TENSOR_DOT_JOBCNT_EN
        jc257 = 1;
`else
        jc257 = 0;
`endif
        chk("jobcnt_257", job_count, jc257);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tensor_dot_seq.md
TENSOR_DOT_SEQ -- requirements
Module: tensor_dot_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (synchronous reset, active low).
REQ-002 in_valid input 1: a dot-product job is offered.
REQ-003 in_ready output 1: the block can accept a job.
REQ-004 a_vec input 8: four 2-bit unsigned elements; element i = a_vec[2i+1:2i].
REQ-005 b_vec input 8: four 2-bit unsigned elements, packed the same way as a_vec.
REQ-006 out_valid output 1: result is valid.
REQ-007 out_ready input 1: the consumer accepts the result.
REQ-008 result output 6: unsigned dot product sum(a_i*b_i), range 0..36.
REQ-009 busy output 1: a job is in flight (state other than IDLE).
REQ-010 job_count output 8: number of completed jobs (see Configuration).

Function
REQ-011 The FSM SHALL have states IDLE, MUL0, MUL1 and DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 In IDLE, in_valid=1 at an edge SHALL register a_vec and b_vec and move the FSM to MUL0; in_valid=0 SHALL keep the FSM in IDLE.
REQ-014 The block SHALL contain exactly two 2x2-bit unsigned multipliers (4-bit products), shared across cycles.
REQ-015 MUL0: acc <= a0*b0 + a1*b1; next state MUL1.
REQ-016 MUL1: acc <= acc + a2*b2 + a3*b3; next state DONE.
REQ-017 All additions SHALL be 6 bits wide with no overflow; the maximum value is 36.
REQ-018 out_valid SHALL rise after the 3rd edge counted from the accepting edge (accept edge k, DONE from edge k+2).
REQ-019 In DONE, result SHALL be stable and the FSM SHALL hold until out_ready=1, then go to IDLE at that edge.
REQ-020 No job SHALL be accepted in DONE, even when out_ready=1 and in_valid=1 at the same edge; maximum throughput is one job per 4 cycles.
REQ-021 Operand inputs SHALL be ignored outside IDLE; changing them mid-job SHALL NOT affect result.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 result SHALL hold the last completed value in IDLE, MUL0 and MUL1, and SHALL be 0 until the first completion.

Reset
REQ-024 rst_n=0 at an edge SHALL force: state IDLE, acc/result 0, operand registers 0, job_count 0.
REQ-025 Reset SHALL take priority over all other inputs.
REQ-026 Reset during MUL0, MUL1 or DONE SHALL discard the job with no out_valid pulse.
REQ-027 After reset: in_ready=1, out_valid=0, busy=0.

Configuration
REQ-028 The macro TENSOR_DOT_JOBCNT_EN SHALL control the job counter.
REQ-029 When TENSOR_DOT_JOBCNT_EN is defined, job_count SHALL increment on each DONE->IDLE transition and wrap from 255 to 0.
REQ-030 When TENSOR_DOT_JOBCNT_EN is not defined, job_count SHALL be constant 0, with no counter flops; all other behaviour SHALL be identical.

Verification
REQ-031 a_vec=0xFF, b_vec=0xFF, out_ready=1 -> out_valid after 3 edges, result=36, returns to IDLE at the next edge.
REQ-032 a_vec=0x1B (e3..e0 = 0,1,2,3), b_vec=0xFF -> result=18; a_vec=0x00 -> result=0.
REQ-033 out_ready=0 for 5 cycles in DONE -> out_valid and result held; in_ready=0 throughout; in_valid ignored.
REQ-034 Assert rst_n=0 in MUL1 -> next cycle state IDLE, result=0, no out_valid; then a new job computes correctly.
REQ-035 Change a_vec/b_vec every cycle after accept -> result matches the operands captured at accept.
REQ-036 With TENSOR_DOT_JOBCNT_EN defined, run 257 jobs -> job_count=1; without the macro -> job_count=0 throughout.
